seq_multiplier_32bit: RTL and testbench

Sequential radix-2 shift-add multiplier producing the full 64-bit product of two 32-bit operands in 32 clock cycles. It is the arithmetic workhorse of the neuron potential-update datapath, e.g. the Izhikevich `b·v` and `a·(b·v − u)` terms. It trades latency for area: one adder and one shift per cycle, with a start/done handshake.

---
 rtl/seq_multiplier_32bit.sv | 93 +++++++++
 tb/tb_seq_multiplier_32bit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_32bit.sv
// Radix-2 shift-add multiplier, 32x32 -> 64 bits in 32 iterations with a start/done handshake.
// Build option: define MULT_SIGNED_EN for two's-complement operands and result.
module seq_multiplier_32bit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [63:0] result,
   output logic        done
);

   // state   | meaning
   // ST_IDLE | waiting for start; outputs hold the last product
   // ST_BUSY | one multiplier bit per clock, LSB first
   // ST_DONE | product published; waits for start to drop
   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

   state_t      r_state;
   logic [63:0] r_mcand;
   logic [63:0] r_acc;
   logic [31:0] r_mplier;
   logic [4:0]  r_cnt;
   logic        r_neg;
   logic [63:0] r_result;
   logic        r_done;

   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic        w_neg;
   logic [63:0] w_acc_next;
   logic [63:0] w_prod;

`ifdef MULT_SIGNED_EN
   // -2^31 maps to 32'h80000000, which is its correct unsigned magnitude.
   assign w_a_mag = A[31] ? (~A + 32'd1) : A;
   assign w_b_mag = B[31] ? (~B + 32'd1) : B;
   assign w_neg   = A[31] ^ B[31];
`else
   assign w_a_mag = A;
   assign w_b_mag = B;
   assign w_neg   = 1'b0;
`endif

   assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_prod     = r_neg ? (~w_acc_next + 64'd1) : w_acc_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_mcand  <= 64'h0;
         r_acc    <= 64'h0;
         r_mplier <= 32'h0;
         r_cnt    <= 5'd0;
         r_neg    <= 1'b0;
         r_result <= 64'h0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_mcand  <= {32'h0, w_a_mag};
                  r_mplier <= w_b_mag;
                  r_acc    <= 64'h0;
                  r_cnt    <= 5'd0;
                  r_neg    <= w_neg;
                  r_done   <= 1'b0;
                  r_state  <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 5'd1;
               if (r_cnt == 5'd31) begin
                  r_result <= w_prod;
                  r_done   <= 1'b1;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!start) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign result = r_result;
   assign done   = r_done;

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Directed bench for seq_multiplier_32bit; expectations follow MULT_SIGNED_EN when defined.
module tb_seq_multiplier_32bit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic [63:0] result;
   logic        done;

   int total;
   int bad;

   seq_multiplier_32bit dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .A      (a),
      .B      (b),
      .result (result),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one clock; sample/drive 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // accept then 32 iterations with start released, ending right after the completion edge
   task automatic do_op(input logic [31:0] av, input logic [31:0] bv);
      a = av;
      b = bv;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (32) step();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start = 1'b0;
      a = 32'h0;
      b = 32'h0;
      step();
      step();
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL reset_done: got %b want 0", done);
      end
      total++;
      if (result !== 64'h0) begin
         bad++;
         $display("FAIL reset_result: got %h want 0", result);
      end
      // release with start high: first edge after release is the accept edge
      start = 1'b1;
      a = 32'd3;
      b = 32'd5;
      rst = 1'b1;
   endtask

   task automatic test_basic();
      step();
      start = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         if (i > 1) step();
         if (i < 32) begin
            total++;
            if (done !== 1'b0) begin
               bad++;
               $display("FAIL basic_busy_done cycle %0d: got %b want 0", i, done);
            end
         end
      end
      step();
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL basic_done: got %b want 1", done);
      end
      total++;
      if (result !== 64'd15) begin
         bad++;
         $display("FAIL basic_result: got %h want %h", result, 64'd15);
      end
      step();
      total++;
      if (done !== 1'b1 || result !== 64'd15) begin
         bad++;
         $display("FAIL basic_hold_in_idle: done %b result %h want 1 %h", done, result, 64'd15);
      end
   endtask

   task automatic test_vectors();
      logic [31:0] va [4];
      logic [31:0] vb [4];
      logic [63:0] ve [4];
      va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF;
      va[1] = 32'hFFFFFFFE; vb[1] = 32'd3;
      va[2] = 32'h80000000; vb[2] = 32'h80000000;
      va[3] = 32'h12345678; vb[3] = 32'd0;
`ifdef MULT_SIGNED_EN
      ve[0] = 64'h0000000000000001;
      ve[1] = 64'hFFFFFFFFFFFFFFFA;
`else
      ve[0] = 64'hFFFFFFFE00000001;
      ve[1] = 64'h00000002FFFFFFFA;
`endif
      ve[2] = 64'h4000000000000000;
      ve[3] = 64'h0;
      for (int k = 0; k < 4; k++) begin
         do_op(va[k], vb[k]);
         total++;
         if (done !== 1'b1 || result !== ve[k]) begin
            bad++;
            $display("FAIL vector_%0d: done %b result %h want 1 %h", k, done, result, ve[k]);
         end
         step();
      end
   endtask

   task automatic test_held_start();
      logic seen_drop;
      a = 32'd7;
      b = 32'd6;
      start = 1'b1;
      step();
      repeat (31) step();
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL held_early_done: got %b want 0", done);
      end
      step();
      total++;
      if (done !== 1'b1 || result !== 64'd42) begin
         bad++;
         $display("FAIL held_first: done %b result %h want 1 %h", done, result, 64'd42);
      end
      seen_drop = 1'b0;
      repeat (28) begin
         step();
         if (done !== 1'b1 || result !== 64'd42) seen_drop = 1'b1;
      end
      total++;
      if (seen_drop !== 1'b0) begin
         bad++;
         $display("FAIL held_no_restart: got restart=%b want 0", seen_drop);
      end
      start = 1'b0;
      step();
      a = 32'd2;
      b = 32'd2;
      start = 1'b1;
      step();
      total++;
      if (done !== 1'b0 || result !== 64'd42) begin
         bad++;
         $display("FAIL rearm_accept: done %b result %h want 0 %h", done, result, 64'd42);
      end
      start = 1'b0;
      repeat (31) step();
      total++;
      if (done !== 1'b0 || result !== 64'd42) begin
         bad++;
         $display("FAIL rearm_busy: done %b result %h want 0 %h", done, result, 64'd42);
      end
      step();
      total++;
      if (done !== 1'b1 || result !== 64'd4) begin
         bad++;
         $display("FAIL rearm_result: done %b result %h want 1 %h", done, result, 64'd4);
      end
      step();
   endtask

   task automatic test_operand_change();
      a = 32'd100;
      b = 32'd100;
      start = 1'b1;
      step();
      step();
      step();
      a = 32'd0;
      b = 32'd0;
      start = 1'b0;
      repeat (30) step();
      total++;
      if (done !== 1'b1 || result !== 64'd10000) begin
         bad++;
         $display("FAIL operand_change: done %b result %h want 1 %h", done, result, 64'd10000);
      end
      step();
   endtask

   task automatic test_async_reset();
      logic spurious;
      a = 32'd9;
      b = 32'd9;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      #2;
      rst = 1'b0;
      #1;
      total++;
      if (done !== 1'b0 || result !== 64'h0) begin
         bad++;
         $display("FAIL async_reset: done %b result %h want 0 0", done, result);
      end
      step();
      rst = 1'b1;
      spurious = 1'b0;
      repeat (40) begin
         step();
         if (done !== 1'b0 || result !== 64'h0) spurious = 1'b1;
      end
      total++;
      if (spurious !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: got activity=%b want 0", spurious);
      end
      do_op(32'd12, 32'd11);
      total++;
      if (done !== 1'b1 || result !== 64'd132) begin
         bad++;
         $display("FAIL after_reset_op: done %b result %h want 1 %h", done, result, 64'd132);
      end
      step();
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_basic();
      test_vectors();
      test_held_start();
      test_operand_change();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
